// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side and memory-side signals around mem_arbiter.
// master: the arbiter's view. slave: the caches' and memory model's view.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned LINE_SIZE = 128
);
    // icache refill port
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_res;
    logic [WORD_SIZE-1:0] i_res_addr;
    logic [LINE_SIZE-1:0] i_res_data;

    // dcache refill port
    logic                 d_req;
    logic [WORD_SIZE-1:0] d_addr;
    logic                 d_res;
    logic [WORD_SIZE-1:0] d_res_addr;
    logic [LINE_SIZE-1:0] d_res_data;

    // dcache write-back port
    logic                 d_wr;
    logic [WORD_SIZE-1:0] d_wr_addr;
    logic [LINE_SIZE-1:0] d_wr_data;
    logic                 d_wr_done;

    // main-memory port
    logic                 m_req;
    logic                 m_we;
    logic [WORD_SIZE-1:0] m_addr;
    logic [LINE_SIZE-1:0] m_wdata;
    logic                 m_res;
    logic [LINE_SIZE-1:0] m_res_data;

    modport master (
        input  i_req, i_addr,
        output i_res, i_res_addr, i_res_data,
        input  d_req, d_addr,
        output d_res, d_res_addr, d_res_data,
        input  d_wr, d_wr_addr, d_wr_data,
        output d_wr_done,
        output m_req, m_we, m_addr, m_wdata,
        input  m_res, m_res_data
    );

    modport slave (
        output i_req, i_addr,
        input  i_res, i_res_addr, i_res_data,
        output d_req, d_addr,
        input  d_res, d_res_addr, d_res_data,
        output d_wr, d_wr_addr, d_wr_data,
        input  d_wr_done,
        input  m_req, m_we, m_addr, m_wdata,
        output m_res, m_res_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: serialises icache refills, dcache refills and dcache
// write-backs onto one memory port, one transaction outstanding at a time.
// Writes win; reads round-robin. A watchdog ends a transaction the memory
// never answers, returning a zero line and raising a sticky error.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned LINE_SIZE = 128,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output logic          busy,
    output logic          mem_err
);

    localparam int unsigned OFF_W = $clog2(LINE_SIZE / 8);
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = {WORD_SIZE{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]     CNT_MAX    = CNT_W'(TIMEOUT);

    // last_read encoding: which read requester was granted most recently
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_I,
        OWN_D,
        OWN_W
    } owner_t;

    state_t           state;
    owner_t           owner;
    logic             last_read;
    logic [CNT_W-1:0] wd_cnt;

    logic                 grant_w_c;
    logic                 grant_i_c;
    logic                 grant_d_c;
    logic                 wd_expired_c;
    logic [LINE_SIZE-1:0] resp_line_c;

    // Grant selection from the requests seen this cycle: write first, then
    // the read requester that was not served last.
    always_comb begin
        grant_w_c = 1'b0;
        grant_i_c = 1'b0;
        grant_d_c = 1'b0;
        if (bus.d_wr) begin
            grant_w_c = 1'b1;
        end else if (bus.i_req && bus.d_req) begin
            if (last_read == LAST_D) begin
                grant_i_c = 1'b1;
            end else begin
                grant_d_c = 1'b1;
            end
        end else if (bus.i_req) begin
            grant_i_c = 1'b1;
        end else if (bus.d_req) begin
            grant_d_c = 1'b1;
        end
    end

    // Line handed back to the owner: memory data, or zeros on a watchdog expiry.
    always_comb begin
        wd_expired_c = (wd_cnt == CNT_MAX);
        resp_line_c  = bus.m_res ? bus.m_res_data : '0;
    end

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            owner          <= OWN_I;
            last_read      <= LAST_D;
            wd_cnt         <= '0;
            busy           <= 1'b0;
            mem_err        <= 1'b0;
            bus.m_req      <= 1'b0;
            bus.m_we       <= 1'b0;
            bus.m_addr     <= '0;
            bus.m_wdata    <= '0;
            bus.i_res      <= 1'b0;
            bus.i_res_addr <= '0;
            bus.i_res_data <= '0;
            bus.d_res      <= 1'b0;
            bus.d_res_addr <= '0;
            bus.d_res_data <= '0;
            bus.d_wr_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // m_addr doubles as the latched transaction address
                    if (grant_w_c) begin
                        owner       <= OWN_W;
                        bus.m_we    <= 1'b1;
                        bus.m_addr  <= bus.d_wr_addr & ALIGN_MASK;
                        bus.m_wdata <= bus.d_wr_data;
                    end else if (grant_i_c) begin
                        owner       <= OWN_I;
                        last_read   <= LAST_I;
                        bus.m_we    <= 1'b0;
                        bus.m_addr  <= bus.i_addr & ALIGN_MASK;
                        bus.m_wdata <= '0;
                    end else if (grant_d_c) begin
                        owner       <= OWN_D;
                        last_read   <= LAST_D;
                        bus.m_we    <= 1'b0;
                        bus.m_addr  <= bus.d_addr & ALIGN_MASK;
                        bus.m_wdata <= '0;
                    end
                    if (grant_w_c || grant_i_c || grant_d_c) begin
                        bus.m_req <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    bus.m_req <= 1'b0;
                    bus.m_we  <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.m_res || wd_expired_c) begin
                        if (!bus.m_res) begin
                            mem_err <= 1'b1;
                        end
                        case (owner)
                            OWN_I: begin
                                bus.i_res      <= 1'b1;
                                bus.i_res_addr <= bus.m_addr;
                                bus.i_res_data <= resp_line_c;
                            end
                            OWN_D: begin
                                bus.d_res      <= 1'b1;
                                bus.d_res_addr <= bus.m_addr;
                                bus.d_res_data <= resp_line_c;
                            end
                            OWN_W: begin
                                bus.d_wr_done <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                        state <= ST_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    bus.i_res     <= 1'b0;
                    bus.d_res     <= 1'b0;
                    bus.d_wr_done <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester/memory models plus event logs,
// checked against hand-computed cycle numbers, addresses and lines.
module tb_mem_arbiter;

    localparam int unsigned WS = 32;
    localparam int unsigned LS = 128;
    localparam int unsigned TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic mem_err;

    mem_arbiter_if #(.WORD_SIZE(WS), .LINE_SIZE(LS)) bus ();

    mem_arbiter #(
        .WORD_SIZE(WS),
        .LINE_SIZE(LS),
        .TIMEOUT  (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a, ~a, a + 32'h1, 32'hDEAD_BEEF};
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: answers m_req after mem_lat cycles unless switched off
    logic        mem_on  = 1'b1;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;

    always @(negedge clk) begin
        bus.m_res      = 1'b0;
        bus.m_res_data = '0;
        if (mem_pend) begin
            if (mem_cnt == 1) begin
                bus.m_res      = 1'b1;
                bus.m_res_data = line_of(mem_addr);
                mem_pend       = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (bus.m_req && mem_on) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = bus.m_addr;
        end
    end

    // event logs and requester model
    typedef struct {
        int           cyc;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] data;
    } ev_t;

    ev_t mreq_q[$];
    ev_t ires_q[$];
    ev_t dres_q[$];
    ev_t wdone_q[$];
    int  err_cyc = -1;

    int i_want = 0, d_want = 0, w_want = 0;
    int i_served = 0, d_served = 0, w_served = 0;

    always @(negedge clk) begin
        if (bus.m_req)     mreq_q.push_back('{cyc, bus.m_we, bus.m_addr, bus.m_wdata});
        if (bus.i_res)     ires_q.push_back('{cyc, 1'b0, bus.i_res_addr, bus.i_res_data});
        if (bus.d_res)     dres_q.push_back('{cyc, 1'b0, bus.d_res_addr, bus.d_res_data});
        if (bus.d_wr_done) wdone_q.push_back('{cyc, 1'b1, 32'h0, 128'h0});
        if (mem_err && err_cyc < 0) err_cyc = cyc;
        if (!rst) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            bus.d_wr  = 1'b0;
        end else begin
            if (bus.i_res) begin
                bus.i_req = 1'b0;
                i_served++;
            end else if (i_served < i_want && !bus.i_req) begin
                bus.i_req = 1'b1;
            end
            if (bus.d_res) begin
                bus.d_req = 1'b0;
                d_served++;
            end else if (d_served < d_want && !bus.d_req) begin
                bus.d_req = 1'b1;
            end
            if (bus.d_wr_done) begin
                bus.d_wr = 1'b0;
                w_served++;
            end else if (w_served < w_want && !bus.d_wr) begin
                bus.d_wr = 1'b1;
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c0, bm, bi, bd, bw;
    logic [31:0]  exp_addr [3];
    int           exp_cyc  [3];
    logic         exp_we   [3];
    logic [127:0] wline;

    initial begin
        bus.i_addr    = '0;
        bus.d_addr    = '0;
        bus.d_wr_addr = '0;
        bus.d_wr_data = '0;

        // reset state
        run(3);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err", 128'(mem_err), 128'(0));
        check("rst_mreq", 128'(bus.m_req), 128'(0));
        check("rst_res", 128'({bus.i_res, bus.d_res, bus.d_wr_done}), 128'(0));
        check("rst_maddr", 128'(bus.m_addr), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        run(2);

        // three simultaneous requests, 1-cycle memory
        bus.i_addr    = 32'h0000_0104;
        bus.d_addr    = 32'h0000_020C;
        bus.d_wr_addr = 32'h0000_0300;
        bus.d_wr_data = line_of(32'h0000_7777);
        mem_lat = 1;
        bm = mreq_q.size(); bi = ires_q.size(); bd = dres_q.size(); bw = wdone_q.size();
        c0 = cyc;
        i_want++; d_want++; w_want++;
        run(16);
        exp_cyc  = '{1, 5, 9};
        exp_we   = '{1'b1, 1'b0, 1'b0};
        exp_addr = '{32'h300, 32'h100, 32'h200};
        check("tri_nreq", 128'(mreq_q.size() - bm), 128'(3));
        if (mreq_q.size() >= bm + 3) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("tri_req%0d_cyc", k), 128'(mreq_q[bm+k].cyc - c0), 128'(exp_cyc[k]));
                check($sformatf("tri_req%0d_we", k), 128'(mreq_q[bm+k].we), 128'(exp_we[k]));
                check($sformatf("tri_req%0d_addr", k), 128'(mreq_q[bm+k].addr), 128'(exp_addr[k]));
            end
        end
        check("tri_nwdone", 128'(wdone_q.size() - bw), 128'(1));
        check("tri_nires", 128'(ires_q.size() - bi), 128'(1));
        check("tri_ndres", 128'(dres_q.size() - bd), 128'(1));
        if (wdone_q.size() > bw) check("tri_wdone_cyc", 128'(wdone_q[bw].cyc - c0), 128'(3));
        if (ires_q.size() > bi) begin
            check("tri_ires_cyc", 128'(ires_q[bi].cyc - c0), 128'(7));
            check("tri_ires_addr", 128'(ires_q[bi].addr), 128'(32'h100));
            check("tri_ires_data", ires_q[bi].data, line_of(32'h100));
        end
        if (dres_q.size() > bd) begin
            check("tri_dres_cyc", 128'(dres_q[bd].cyc - c0), 128'(11));
            check("tri_dres_addr", 128'(dres_q[bd].addr), 128'(32'h200));
            check("tri_dres_data", dres_q[bd].data, line_of(32'h200));
        end

        // round-robin: both reads held and re-raised, 8 transactions
        bus.i_addr = 32'h0000_1000;
        bus.d_addr = 32'h0000_2008;
        bm = mreq_q.size(); bi = ires_q.size(); bd = dres_q.size();
        i_want += 4; d_want += 4;
        run(40);
        check("rr_nreq", 128'(mreq_q.size() - bm), 128'(8));
        if (mreq_q.size() >= bm + 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("rr_grant%0d", k), 128'(mreq_q[bm+k].addr),
                      (k % 2 == 0) ? 128'(32'h1000) : 128'(32'h2000));
            end
        end
        check("rr_nires", 128'(ires_q.size() - bi), 128'(4));
        check("rr_ndres", 128'(dres_q.size() - bd), 128'(4));

        // single icache read, 3-cycle memory, 16-byte alignment
        bus.i_addr = 32'h0000_1234;
        mem_lat = 3;
        bm = mreq_q.size(); bi = ires_q.size(); bd = dres_q.size();
        c0 = cyc;
        i_want++;
        run(12);
        check("ic_nreq", 128'(mreq_q.size() - bm), 128'(1));
        if (mreq_q.size() > bm) begin
            check("ic_req_cyc", 128'(mreq_q[bm].cyc - c0), 128'(1));
            check("ic_req_we", 128'(mreq_q[bm].we), 128'(0));
            check("ic_req_addr", 128'(mreq_q[bm].addr), 128'(32'h1230));
        end
        check("ic_nires", 128'(ires_q.size() - bi), 128'(1));
        if (ires_q.size() > bi) begin
            check("ic_res_cyc", 128'(ires_q[bi].cyc - c0), 128'(5));
            check("ic_res_addr", 128'(ires_q[bi].addr), 128'(32'h1230));
            check("ic_res_data", ires_q[bi].data, line_of(32'h1230));
        end
        check("ic_ndres", 128'(dres_q.size() - bd), 128'(0));

        // write-back
        wline = {16{8'hA5}};
        bus.d_wr_addr = 32'h0000_0080;
        bus.d_wr_data = wline;
        mem_lat = 1;
        bm = mreq_q.size(); bi = ires_q.size(); bd = dres_q.size(); bw = wdone_q.size();
        c0 = cyc;
        w_want++;
        run(8);
        check("wb_nreq", 128'(mreq_q.size() - bm), 128'(1));
        if (mreq_q.size() > bm) begin
            check("wb_we", 128'(mreq_q[bm].we), 128'(1));
            check("wb_addr", 128'(mreq_q[bm].addr), 128'(32'h80));
            check("wb_wdata", mreq_q[bm].data, wline);
        end
        check("wb_ndone", 128'(wdone_q.size() - bw), 128'(1));
        if (wdone_q.size() > bw) check("wb_done_cyc", 128'(wdone_q[bw].cyc - c0), 128'(3));
        check("wb_nores", 128'((ires_q.size() - bi) + (dres_q.size() - bd)), 128'(0));

        // watchdog: memory silent
        mem_on = 1'b0;
        bus.d_addr = 32'h0000_4000;
        bd = dres_q.size();
        c0 = cyc;
        d_want++;
        run(int'(TO) + 10);
        check("wd_ndres", 128'(dres_q.size() - bd), 128'(1));
        if (dres_q.size() > bd) begin
            check("wd_res_cyc", 128'(dres_q[bd].cyc - c0), 128'(TO + 3));
            check("wd_res_data", dres_q[bd].data, 128'(0));
            check("wd_res_addr", 128'(dres_q[bd].addr), 128'(32'h4000));
        end
        check("wd_err_cyc", 128'(err_cyc - c0), 128'(TO + 3));
        check("wd_err", 128'(mem_err), 128'(1));
        mem_on = 1'b1;
        bus.i_addr = 32'h0000_5000;
        bi = ires_q.size();
        i_want++;
        run(8);
        check("wd_next_nires", 128'(ires_q.size() - bi), 128'(1));
        if (ires_q.size() > bi) check("wd_next_data", ires_q[bi].data, line_of(32'h5000));
        check("wd_err_sticky", 128'(mem_err), 128'(1));

        // reset in WAIT, then a stale m_res
        mem_lat = 6;
        bus.d_addr = 32'h0000_6000;
        bm = mreq_q.size(); bd = dres_q.size();
        d_want++;
        repeat (3) @(posedge clk);
        #2;
        check("rw_busy_pre", 128'(busy), 128'(1));
        rst = 1'b0;
        d_want = d_served;
        #1;
        check("rw_busy", 128'(busy), 128'(0));
        check("rw_err", 128'(mem_err), 128'(0));
        check("rw_maddr", 128'(bus.m_addr), 128'(0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        run(10);
        check("rw_ndres", 128'(dres_q.size() - bd), 128'(0));
        check("rw_nreq", 128'(mreq_q.size() - bm), 128'(1));
        check("rw_idle", 128'(busy), 128'(0));
        check("rw_err_post", 128'(mem_err), 128'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction cache (line refills), the data cache (line refills) and the data-cache write-back path. It sits between the fetch/memory-stage caches and the memory model. It serialises transactions with one outstanding at a time, arbitrates writes-first and then round-robin between reads, and routes each response back to the requester that issued it. A watchdog flags a memory port that never responds.

## Interface
- WORD_SIZE, `WORD_SIZE, address width in bits
- LINE_SIZE, `CACHE_LINE_SIZE, line width in bits (power of two, ≥ 8)
- TIMEOUT, 255, max cycles in WAIT before error (fits 8-bit counter)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  icache refill request, level, held until i_res
- i_addr  in  WORD_SIZE  icache refill address
- i_res  out  1  icache response pulse (1 cycle)
- i_res_addr  out  WORD_SIZE  line-aligned address of the returned line
- i_res_data  out  LINE_SIZE  returned line
- d_req, d_addr, d_res, d_res_addr, d_res_data  same as i_* for dcache refills
- d_wr  in  1  dcache write-back request, level, held until d_wr_done
- d_wr_addr  in  WORD_SIZE  write-back address
- d_wr_data  in  LINE_SIZE  write-back line
- d_wr_done  out  1  write-back complete pulse (1 cycle)
- m_req  out  1  memory request pulse (1 cycle)
- m_we  out  1  1 = write, valid with m_req
- m_addr  out  WORD_SIZE  line-aligned address, valid with m_req
- m_wdata  out  LINE_SIZE  write data, valid with m_req
- m_res  in  1  memory completion pulse, for reads and writes
- m_res_data  in  LINE_SIZE  read data, valid with m_res
- busy  out  1  state ≠ IDLE
- mem_err  out  1  sticky watchdog error, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: the grant is chosen from requests sampled this cycle.
  - Priority: d_wr first.
  - Otherwise round-robin between i_req and d_req using a `last_read` bit, which is updated only on read grants. Reset value of `last_read` = dcache, so icache wins the first tie.
  - On grant, latch owner (I, D or W), line-aligned address (low log2(LINE_SIZE/8) bits zeroed) and, for writes, d_wr_data. Go to ISSUE.
- ISSUE: m_req = 1, m_we = (owner == W), m_addr and m_wdata from the latches. Clear the watchdog counter. Go to WAIT.
- WAIT: count cycles.
  - On m_res: latch m_res_data and go to RESP.
  - If the counter reaches TIMEOUT with no m_res: set mem_err and go to RESP; the returned data is all zeros.
- RESP: pulse exactly one of i_res, d_res or d_wr_done according to the owner. i_res_addr/d_res_addr = latched address; *_res_data = latched line. Go to IDLE.
- Requester rule: a requester drops its req on the clock edge at which it samples its res/done high. The arbiter never re-grants a request inside the same transaction.
- m_res outside WAIT is ignored, including a stale response after reset.
- Request inputs and addresses are sampled only in IDLE. Changes during a transaction are ignored until the next IDLE.
- All outputs are registered.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE; all outputs 0, including mem_err; all latches and the counter = 0; last_read = dcache.
- Minimum transaction length: grant in IDLE at cycle T; m_req at T+1; m_res at the earliest T+2; res pulse at T+3; IDLE at T+4. With a 1-cycle memory, back-to-back grants are therefore 4 cycles apart.
- Latency from m_res to the requester's res pulse = 1 cycle.
- Simultaneous events:
  - d_wr and d_req together: the write is granted first, then the read on the next IDLE.
  - All three requests together: order W, I, D when last_read = D.
- Reset asserted in ISSUE/WAIT/RESP: the transaction is aborted and no res pulse is produced. The requester must re-request after reset.
- The watchdog counter saturates at TIMEOUT. mem_err stays 1 across subsequent transactions.

## Test plan
- Single icache read: i_req = 1, i_addr = 0x0000_1234, memory responds 3 cycles after m_req with line L. Required: m_req = 1 with m_addr = 0x0000_1230 (16-byte lines), m_we = 0; i_res pulses for exactly 1 cycle with i_res_addr = 0x0000_1230 and i_res_data = L; d_res stays 0.
- Three simultaneous requests, 1-cycle memory, starting from reset. Required: grants in order W, I, D; m_req pulses at cycles 1, 5 and 9; d_wr_done, i_res and d_res at cycles 3, 7 and 11.
- Round-robin fairness: i_req and d_req held continuously, each re-raised after service. Required: grants strictly alternate I, D, I, D over 8 transactions.
- Write-back: d_wr = 1, d_wr_addr = 0x80, d_wr_data = 0xA5 repeated across the line. Required: m_we = 1, m_wdata matches, d_wr_done 1 cycle after m_res; i_res and d_res never pulse.
- Watchdog: grant a read and never drive m_res. Required: mem_err = 1 and a res pulse with zero data TIMEOUT+1 cycles after WAIT entry; the next transaction still completes; mem_err stays 1.
- Reset in WAIT: assert rst = 0 for one cycle mid-WAIT, then drive m_res. Required: outputs 0 immediately (asynchronously); state IDLE; the stale m_res is ignored and no res pulse is produced.
